// File: rtl/myproject_acc_requant_25s_16s_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : myproject_acc_pkg                                          |
// | Description : Shared widths, rounding/saturation constants and result    |
// |               type for the product-accumulate requant stage.             |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package myproject_acc_pkg;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int PROD_W  = 25;
  localparam int N_TERMS = 16;
  localparam int CNT_W   = clog2(N_TERMS);
  // Wide enough that N_TERMS full-scale products can never overflow.
  localparam int ACC_W   = PROD_W + CNT_W;
  localparam int SHIFT   = 8;
  localparam int OUT_W   = 16;

  localparam int ROUND_C = 1 << (SHIFT - 1);
  localparam int SAT_MAX = (1 << (OUT_W - 1)) - 1;
  localparam int SAT_MIN = -(1 << (OUT_W - 1));

  typedef struct packed {
    logic signed [OUT_W-1:0] data;
    logic                    sat;
  } result_t;

endpackage
`default_nettype wire

// File: rtl/myproject_acc_requant_25s_16s_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : myproject_acc_requant_25s_16s_if                           |
// | Description : Product input stream and requantized result stream, both  |
// |               valid/ready. slave = the accumulator, master = its peers.  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
interface myproject_acc_requant_25s_16s_if;
  import myproject_acc_pkg::*;

  logic signed [PROD_W-1:0] in_product;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_sat;
  logic                     out_valid;
  logic                     out_ready;

  modport slave (
    input  in_product, in_valid, out_ready,
    output in_ready, out_data, out_sat, out_valid
  );

  modport master (
    output in_product, in_valid, out_ready,
    input  in_ready, out_data, out_sat, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/myproject_acc_requant_25s_16s_round_sat.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : myproject_round_sat                                        |
// | Description : Round-half-up arithmetic right shift of an ACC_W-bit sum,  |
// |               then saturate to OUT_W signed with a clip flag.            |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module myproject_round_sat
  import myproject_acc_pkg::*;
(
  input  logic signed [ACC_W-1:0] sum_i,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    sat_o
);

  // One extra bit so the rounding addend can never wrap.
  localparam logic signed [ACC_W:0] c_round = (ACC_W+1)'(ROUND_C);
  localparam logic signed [ACC_W:0] c_max   = (ACC_W+1)'(SAT_MAX);
  localparam logic signed [ACC_W:0] c_min   = (ACC_W+1)'(SAT_MIN);

  logic signed [ACC_W:0] w_rnd;
  logic signed [ACC_W:0] w_shr;

  // Add half an LSB, shift arithmetically, then clip into the output range.
  always_comb begin
    w_rnd  = $signed({sum_i[ACC_W-1], sum_i}) + c_round;
    w_shr  = w_rnd >>> SHIFT;
    data_o = w_shr[OUT_W-1:0];
    sat_o  = 1'b0;
    if (w_shr > c_max) begin
      data_o = c_max[OUT_W-1:0];
      sat_o  = 1'b1;
    end else if (w_shr < c_min) begin
      data_o = c_min[OUT_W-1:0];
      sat_o  = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/myproject_acc_requant_25s_16s.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : myproject_acc_requant_25s_16s                              |
// | Description : Sums N_TERMS signed products per group, requantizes the    |
// |               sum and emits one saturated result per group. The next     |
// |               group accumulates while a result waits downstream.         |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module myproject_acc_requant_25s_16s
  import myproject_acc_pkg::*;
(
  input  logic                                  ap_clk,
  input  logic                                  ap_rst_n,
  myproject_acc_requant_25s_16s_if.slave        bus
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(N_TERMS - 1);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  result_t                 res_q, res_d;
  logic                    out_valid_q, out_valid_d;

  logic                    w_last;
  logic                    w_in_ready;
  logic                    w_in_xfer;
  logic                    w_out_xfer;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [OUT_W-1:0] w_rs_data;
  logic                    w_rs_sat;

  // Only the closing term of a group can stall, and only while the previous
  // result is still unconsumed; a same-cycle output transfer frees the slot.
  assign w_last     = (cnt_q == c_cnt_last);
  assign w_in_ready = !(w_last && out_valid_q && !bus.out_ready);
  assign w_in_xfer  = bus.in_valid && w_in_ready;
  assign w_out_xfer = out_valid_q && bus.out_ready;
  assign w_sum      = acc_q + $signed({{(ACC_W-PROD_W){bus.in_product[PROD_W-1]}},
                                       bus.in_product});

  myproject_round_sat u_round_sat (
    .sum_i  (w_sum),
    .data_o (w_rs_data),
    .sat_o  (w_rs_sat)
  );

  // Next-state: accumulate, close a group into the output register, retire output.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    if (w_out_xfer) begin
      out_valid_d = 1'b0;
    end
    if (w_in_xfer) begin
      if (w_last) begin
        acc_d       = '0;
        cnt_d       = '0;
        res_d.data  = w_rs_data;
        res_d.sat   = w_rs_sat;
        out_valid_d = 1'b1;
      end else begin
        acc_d = w_sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset discards any partial sum and pending result.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = res_q.data;
  assign bus.out_sat   = res_q.sat;
  assign bus.out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_myproject_acc_requant_25s_16s.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_myproject_acc_requant_25s_16s                           |
// | Description : Directed and randomized self-checking bench for the        |
// |               accumulate/requantize stage.                               |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_myproject_acc_requant_25s_16s;
  import myproject_acc_pkg::*;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;

  myproject_acc_requant_25s_16s_if u_if ();

  myproject_acc_requant_25s_16s u_dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (u_if)
  );

  always #5 ap_clk = ~ap_clk;

  int     n_chk = 0;
  int     n_pass = 0;
  int     out_cnt = 0;
  bit     rnd_en = 1'b0;
  bit     rnd_ready_en = 1'b0;
  bit     prev_stall = 1'b0;
  longint prev_data, prev_sat;
  longint exp_d_q[$];
  longint exp_s_q[$];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference requantizer: round half up, shift by 8, clip to 16-bit signed.
  function automatic void model(input longint sum, output longint d, output longint s);
    longint r;
    r = (sum + 128) >>> 8;
    s = 0;
    d = r;
    if (r > 32767) begin d = 32767; s = 1; end
    else if (r < -32768) begin d = -32768; s = 1; end
  endfunction

  // Output monitor: sampled on the falling edge, between driver updates.
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (prev_stall) begin
        check("hold_valid", u_if.out_valid, 1);
        check("hold_data", u_if.out_data, prev_data);
        check("hold_sat", u_if.out_sat, prev_sat);
      end
      prev_stall = u_if.out_valid && !u_if.out_ready;
      prev_data  = u_if.out_data;
      prev_sat   = u_if.out_sat;
      if (u_if.out_valid && u_if.out_ready) begin
        out_cnt++;
        if (rnd_en) begin
          if (exp_d_q.size() == 0) check("rnd_extra_out", 1, 0);
          else begin
            check("rnd_data", u_if.out_data, exp_d_q.pop_front());
            check("rnd_sat", u_if.out_sat, exp_s_q.pop_front());
          end
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Random backpressure for the overlap test.
  always @(posedge ap_clk) begin
    if (rnd_ready_en) begin
      #1;
      u_if.out_ready = 1'($urandom_range(1));
    end
  end

  // Present one product and hold it until accepted; returns just after that edge.
  task automatic push(input longint p);
    int t;
    u_if.in_valid   = 1'b1;
    u_if.in_product = PROD_W'(p);
    t = 0;
    @(negedge ap_clk);
    while (!u_if.in_ready && t < 200) begin
      @(negedge ap_clk);
      t++;
    end
    if (t >= 200) check("push_timeout", 0, 1);
    @(posedge ap_clk);
    #1;
    u_if.in_valid = 1'b0;
  endtask

  task automatic group(input string tag, input longint first, input longint rest,
                       input longint ed, input longint es);
    push(first);
    repeat (N_TERMS - 1) push(rest);
    check({tag, "_valid"}, u_if.out_valid, 1);
    check({tag, "_data"}, u_if.out_data, ed);
    check({tag, "_sat"}, u_if.out_sat, es);
    @(posedge ap_clk);
    #1;
    check({tag, "_drain"}, u_if.out_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int     n0, t, mode;
    longint p, sum, d, s;
    u_if.in_valid   = 1'b0;
    u_if.in_product = '0;
    u_if.out_ready  = 1'b1;

    #12;
    check("rst_valid", u_if.out_valid, 0);
    check("rst_data", u_if.out_data, 0);
    check("rst_sat", u_if.out_sat, 0);
    check("rst_in_ready", u_if.in_ready, 1);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;

    group("basic", 256, 256, 16, 0);
    group("rnd_up", 128, 0, 1, 0);
    group("neg_small", -1, -1, 0, 0);
    group("rnd_down", 127, 0, 0, 0);
    group("psat", 16743937, 16743937, 32767, 1);
    group("nsat", -16744448, -16744448, -32768, 1);
    group("edge_max", 8388352, 0, 32767, 0);
    group("edge_pclip", 8388480, 0, 32767, 1);
    group("edge_min", -8388608, 0, -32768, 0);
    group("edge_nclip", -8388737, 0, -32768, 1);

    // Backpressure: two groups back to back with the output blocked.
    u_if.out_ready = 1'b0;
    n0 = out_cnt;
    repeat (2 * N_TERMS - 1) push(256);
    u_if.in_valid   = 1'b1;
    u_if.in_product = 25'sd256;
    repeat (3) begin
      @(negedge ap_clk);
      check("bp_in_ready", u_if.in_ready, 0);
      check("bp_valid", u_if.out_valid, 1);
      check("bp_data", u_if.out_data, 16);
    end
    @(posedge ap_clk);
    #1;
    u_if.out_ready = 1'b1;
    @(negedge ap_clk);
    check("bp_release_ready", u_if.in_ready, 1);
    @(posedge ap_clk);
    #1;
    u_if.in_valid = 1'b0;
    check("bp_valid2", u_if.out_valid, 1);
    check("bp_data2", u_if.out_data, 16);
    check("bp_xfer1", out_cnt - n0, 1);
    @(posedge ap_clk);
    #1;
    check("bp_drain", u_if.out_valid, 0);
    check("bp_xfer2", out_cnt - n0, 2);

    // Reset in the middle of a group.
    repeat (5) push(1000);
    #3;
    ap_rst_n = 1'b0;
    #1;
    check("mrst_valid", u_if.out_valid, 0);
    check("mrst_data", u_if.out_data, 0);
    check("mrst_sat", u_if.out_sat, 0);
    @(posedge ap_clk);
    @(negedge ap_clk);
    check("mrst_hold_valid", u_if.out_valid, 0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    n0 = out_cnt;
    repeat (N_TERMS - 1) push(256);
    check("mrst_no_early_out", out_cnt - n0, 0);
    check("mrst_not_valid", u_if.out_valid, 0);
    push(256);
    check("mrst_valid_out", u_if.out_valid, 1);
    check("mrst_data_out", u_if.out_data, 16);
    @(posedge ap_clk);
    #1;

    // Randomized overlap against the reference model.
    rnd_en = 1'b1;
    rnd_ready_en = 1'b1;
    for (int g = 0; g < 1000; g++) begin
      sum  = 0;
      mode = int'($urandom_range(1));
      for (int k = 0; k < N_TERMS; k++) begin
        if (mode == 0) p = longint'($urandom_range(33554431)) - 16777216;
        else           p = longint'($urandom_range(131071)) - 65536;
        sum += p;
        if ($urandom_range(3) == 0) begin
          @(posedge ap_clk);
          #1;
        end
        push(p);
      end
      model(sum, d, s);
      exp_d_q.push_back(d);
      exp_s_q.push_back(s);
    end
    rnd_ready_en = 1'b0;
    @(posedge ap_clk);
    #2;
    u_if.out_ready = 1'b1;
    t = 0;
    while (exp_d_q.size() != 0 && t < 100) begin
      @(posedge ap_clk);
      t++;
    end
    #2;
    check("rnd_drain", exp_d_q.size(), 0);
    rnd_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/myproject_acc_requant_25s_16s.md
Name: myproject_acc_requant_25s_16s

Overview:
- Downstream stage of the 16s x 9ns -> 25-bit signed multiplier in the MHA datapath.
- Consumes a stream of 25-bit signed products and sums N_TERMS of them per group (one dot product).
- Rescales each sum by an arithmetic right shift with round-half-up, saturates to 16-bit signed, and emits one result per group.
- Valid/ready handshake on both sides; accumulation of the next group overlaps with a stalled output.

Parameters:
- PROD_W, 25, input product width (signed).
- N_TERMS, 16, products per group; must be >= 2.
- ACC_W, 29, accumulator width; PROD_W + clog2(N_TERMS), so no overflow is possible.
- SHIFT, 8, right-shift applied to the final sum; must be >= 1.
- OUT_W, 16, output width (signed).

Ports:
- ap_clk, in, 1, clock; all state updates on the rising edge.
- ap_rst_n, in, 1, asynchronous active-low reset.
- in_product, in, PROD_W, signed product from the multiplier.
- in_valid, in, 1, in_product is valid.
- in_ready, out, 1, block accepts in_product this cycle.
- out_data, out, OUT_W, requantized, saturated group result.
- out_sat, out, 1, out_data was clipped; qualified by out_valid.
- out_valid, out, 1, out_data/out_sat are valid.
- out_ready, in, 1, downstream accepts out_data this cycle.

Behaviour:
- Reset (async assert, sync release): acc=0, cnt=0, out_valid=0, out_data=0, out_sat=0. in_ready is 1 after reset.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- State is cnt (0..N_TERMS-1), acc, and the output register. Logical states:
  - ACCUM: cnt < N_TERMS-1.
  - LAST: cnt == N_TERMS-1.
  - Output register is FULL or EMPTY, orthogonal to the above.
- Non-last transfer (cnt < N_TERMS-1): acc <= acc + sext(in_product); cnt <= cnt+1.
- Last transfer (cnt == N_TERMS-1):
  - sum = acc + sext(in_product).
  - r = (sum + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift).
  - out_data <= clip(r, -2^(OUT_W-1), 2^(OUT_W-1)-1); out_sat <= (r outside that range).
  - out_valid <= 1; acc <= 0; cnt <= 0.
- in_ready = !(cnt == N_TERMS-1 && out_valid && !out_ready).
  - Only the last term of a group can stall, and only while the previous result is unconsumed.
  - Same-cycle output consumption frees the slot, so full throughput of 1 term/cycle is sustained.
- out_valid clears on an output transfer unless a last-term transfer occurs in the same cycle. In that case the new result loads and out_valid stays 1.
- Latency: result registered on the edge that accepts the last term, so out_valid is high the following cycle.
- in_valid low: no state change. in_product is ignored when not transferred.
- out_data and out_sat are held stable while out_valid && !out_ready. out_valid never drops without a transfer.
- Reset mid-group discards the partial sum and any pending result. The next accepted term starts a new group at cnt=0.
- Arithmetic is exact in ACC_W+1 bits, including the rounding addend; no wrap-around anywhere.

Decomposition:
- Package myproject_acc_pkg holds:
  - width constants PROD_W, ACC_W, OUT_W;
  - SHIFT;
  - localparams ROUND_C = 2^(SHIFT-1), SAT_MAX = 2^(OUT_W-1)-1, SAT_MIN = -2^(OUT_W-1);
  - function clog2.
- One combinational sub-module, myproject_round_sat: ACC_W-bit sum in; round, shift and saturate; outputs data and sat flag. It is reused by other requant stages.
- Counter, accumulator and handshake logic stay in the top module.

Test Plan:
- Basic sum: 16 products of 256, out_ready=1 -> sum 4096, out_data=16, out_sat=0, out_valid one cycle after the 16th accept.
- Rounding: first product 128 then 15 zeros -> out_data=1. Sixteen products of -1 (sum -16) -> out_data=0. First product 127 then 15 zeros -> out_data=0.
- Positive saturation: 16 x 16743937 (32767*511) -> out_data=32767, out_sat=1. Negative saturation: 16 x -16744448 -> out_data=-32768, out_sat=1.
- Backpressure: out_ready=0, 32 consecutive products of 256 -> in_ready drops with cnt=15 of group 2. First result 16 is held stable. Raising out_ready -> same-cycle transfer of result 1 and accept of the last term; result 2 = 16 appears next cycle with no term lost.
- Overlap: out_ready toggling pseudo-randomly, random in_valid, 1000 groups of random products -> every out_data matches the reference model and no handshake rule is violated.
- Reset mid-group: accept 5 terms of 1000, pulse ap_rst_n low asynchronously, then 16 terms of 256 -> outputs 0 during reset, then single result 16.
